// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit between the EX/MEM pipeline register and the data bus.
//
// Issues one bus request per aligned load or store held in EX/MEM, stalls the
// pipeline until the access completes, and presents sign- or zero-extended load
// data for exactly one cycle (DONE). Misaligned accesses are not issued; they
// raise a combinational exception flag instead.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   ex2mem_mem_rd/_wr        load / store present (both set = store)
//   ex2mem_alu_out           effective byte address
//   ex2mem_mem_wdata         store data, LSB-aligned
//   ex2mem_mem_size          00 byte, 01 half, 1x word
//   ex2mem_mem_unsigned      zero-extend loads
//   dbus_req/_wr/_addr       bus request, direction, word-aligned address
//   dbus_wdata/_byteen       lane-replicated write data and byte enables
//   dbus_ready               request accepted this cycle
//   dbus_rvalid/_rdata       read data return
//   lsu_rdata                formatted load data (valid only in DONE)
//   lsu_stall                hold IF..EX/MEM
//   lsu_load_misalign        misaligned load exception
//   lsu_store_misalign       misaligned store exception
// -----------------------------------------------------------------------------
module lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex2mem_mem_rd,
    input  logic          ex2mem_mem_wr,
    input  logic [AW-1:0] ex2mem_alu_out,
    input  logic [DW-1:0] ex2mem_mem_wdata,
    input  logic [1:0]    ex2mem_mem_size,
    input  logic          ex2mem_mem_unsigned,
    output logic          dbus_req,
    output logic          dbus_wr,
    output logic [AW-1:0] dbus_addr,
    output logic [DW-1:0] dbus_wdata,
    output logic [3:0]    dbus_byteen,
    input  logic          dbus_ready,
    input  logic          dbus_rvalid,
    input  logic [DW-1:0] dbus_rdata,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_stall,
    output logic          lsu_load_misalign,
    output logic          lsu_store_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Attributes of the accepted access, needed to format the returned word.
    logic [1:0]    cap_off;
    logic [1:0]    cap_size;
    logic          cap_unsigned;
    logic [DW-1:0] cap_word;

    logic is_mem;
    logic misalign;
    logic access;
    logic accept;

    assign is_mem   = ex2mem_mem_rd | ex2mem_mem_wr;
    assign misalign = ((ex2mem_mem_size == 2'b01) & ex2mem_alu_out[0]) |
                      (ex2mem_mem_size[1] & (ex2mem_alu_out[1:0] != 2'b00));
    assign access   = is_mem & ~misalign;
    assign accept   = (state == IDLE) & access & dbus_ready;

    // Shift the addressed lane down to bit 0, then truncate and extend.
    function automatic logic [DW-1:0] fmt_load(input logic [DW-1:0] word,
                                               input logic [1:0]    off,
                                               input logic [1:0]    size,
                                               input logic          uns);
        logic [DW-1:0] shifted;
        logic [DW-1:0] result;
        shifted = word >> {off, 3'b000};
        case (size)
            2'b00:   result = {{(DW-8){~uns & shifted[7]}}, shifted[7:0]};
            2'b01:   result = {{(DW-16){~uns & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    // Bus request payload: stable for as long as EX/MEM holds the instruction.
    assign dbus_wr   = ex2mem_mem_wr;
    assign dbus_addr = {ex2mem_alu_out[AW-1:2], 2'b00};

    always_comb begin
        dbus_wdata  = ex2mem_mem_wdata;
        dbus_byteen = 4'b1111;
        case (ex2mem_mem_size)
            2'b00: begin
                dbus_wdata  = {4{ex2mem_mem_wdata[7:0]}};
                dbus_byteen = 4'b0001 << ex2mem_alu_out[1:0];
            end
            2'b01: begin
                dbus_wdata  = {2{ex2mem_mem_wdata[15:0]}};
                dbus_byteen = 4'b0011 << {ex2mem_alu_out[1], 1'b0};
            end
            default: begin
                dbus_wdata  = ex2mem_mem_wdata;
                dbus_byteen = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cap_off      <= 2'b00;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_word     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_off      <= ex2mem_alu_out[1:0];
                cap_size     <= ex2mem_mem_size;
                cap_unsigned <= ex2mem_mem_unsigned;
            end
            if ((state == WAIT) && dbus_rvalid) begin
                cap_word <= dbus_rdata;
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        dbus_req           = 1'b0;
        lsu_stall          = 1'b0;
        lsu_rdata          = '0;
        lsu_load_misalign  = 1'b0;
        lsu_store_misalign = 1'b0;
        case (state)
            IDLE: begin
                dbus_req           = access;
                lsu_stall          = access;
                // Both rd and wr set is a store, so it reports as a store.
                lsu_store_misalign = ex2mem_mem_wr & misalign;
                lsu_load_misalign  = ex2mem_mem_rd & ~ex2mem_mem_wr & misalign;
                if (access && dbus_ready) begin
                    state_nxt = ex2mem_mem_wr ? DONE : WAIT;
                end
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (dbus_rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // One cycle with stall low lets the pipeline advance past the
                // held instruction, so it is never reissued.
                lsu_rdata = fmt_load(cap_word, cap_off, cap_size, cap_unsigned);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Outputs are quiet while reset is asserted, whatever the inputs.
        if (!rst) begin
            dbus_req           = 1'b0;
            lsu_stall          = 1'b0;
            lsu_rdata          = '0;
            lsu_load_misalign  = 1'b0;
            lsu_store_misalign = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu. Directed scenarios followed by random
// transactions; expected values come from a transaction-level model of the
// access protocol and load formatting.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        ex_rd;
    logic        ex_wr;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [1:0]  ex_size;
    logic        ex_uns;
    logic        dbus_req;
    logic        dbus_wr;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_byteen;
    logic        dbus_ready;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_load_misalign;
    logic        lsu_store_misalign;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_hs     = 0;
    int n_exp_hs = 0;

    lsu #(.AW(32), .DW(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex2mem_mem_rd      (ex_rd),
        .ex2mem_mem_wr      (ex_wr),
        .ex2mem_alu_out     (ex_addr),
        .ex2mem_mem_wdata   (ex_wdata),
        .ex2mem_mem_size    (ex_size),
        .ex2mem_mem_unsigned(ex_uns),
        .dbus_req           (dbus_req),
        .dbus_wr            (dbus_wr),
        .dbus_addr          (dbus_addr),
        .dbus_wdata         (dbus_wdata),
        .dbus_byteen        (dbus_byteen),
        .dbus_ready         (dbus_ready),
        .dbus_rvalid        (dbus_rvalid),
        .dbus_rdata         (dbus_rdata),
        .lsu_rdata          (lsu_rdata),
        .lsu_stall          (lsu_stall),
        .lsu_load_misalign  (lsu_load_misalign),
        .lsu_store_misalign (lsu_store_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count accepted bus requests so reissues can be detected.
    always @(posedge clk) begin
        if (rst && dbus_req && dbus_ready) n_hs <= n_hs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] data, input int off,
                                             input int size, input logic uns);
        logic [31:0] v;
        v = data >> (8 * off);
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic idle(input string tag);
        ex_rd = 1'b0; ex_wr = 1'b0;
        dbus_ready = 1'($urandom % 2); dbus_rvalid = 1'($urandom % 2); dbus_rdata = $urandom;
        #3;
        chk({tag, "_req"},   dbus_req,  0);
        chk({tag, "_stall"}, lsu_stall, 0);
        chk({tag, "_rdata"}, lsu_rdata, 0);
        next_cycle();
    endtask

    // Present one instruction in EX/MEM and follow it to completion.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic uns,
                             input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        int          off;
        off = int'(addr % 4);
        mis = (size == 1 && off % 2 != 0) || (size >= 2 && off != 0);
        if (size == 0) begin
            be = 4'(32'd1 << off);
            wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
        end else if (size == 1) begin
            be = 4'(32'd3 << (off & 2));
            wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
        end else begin
            be = 4'hF;
            wd = wdata;
        end
        ex_rd = rd; ex_wr = wr; ex_addr = addr; ex_wdata = wdata; ex_size = size; ex_uns = uns;

        if (mis) begin
            dbus_ready = 1'b1; dbus_rvalid = 1'($urandom % 2); dbus_rdata = $urandom;
            #3;
            chk({tag, "_mis_req"},   dbus_req,  0);
            chk({tag, "_mis_stall"}, lsu_stall, 0);
            chk({tag, "_mis_rdata"}, lsu_rdata, 0);
            chk({tag, "_lmis"}, lsu_load_misalign,  rd & ~wr);
            chk({tag, "_smis"}, lsu_store_misalign, wr);
            next_cycle();
            return;
        end

        for (int k = 0; k <= rdy_dly; k++) begin
            dbus_ready = (k == rdy_dly); dbus_rvalid = 1'($urandom % 2); dbus_rdata = $urandom;
            #3;
            chk({tag, "_req"},    dbus_req,    1);
            chk({tag, "_wr"},     dbus_wr,     wr);
            chk({tag, "_addr"},   dbus_addr,   (addr / 4) * 4);
            chk({tag, "_byteen"}, dbus_byteen, be);
            if (wr) chk({tag, "_wdata"}, dbus_wdata, wd);
            chk({tag, "_stall_req"}, lsu_stall, 1);
            chk({tag, "_flags"}, {lsu_load_misalign, lsu_store_misalign}, 0);
            next_cycle();
        end
        n_exp_hs++;

        if (!wr) begin
            for (int k = 0; k <= rv_dly; k++) begin
                dbus_ready = 1'($urandom % 2);
                dbus_rvalid = (k == rv_dly);
                dbus_rdata = (k == rv_dly) ? rdata : $urandom;
                #3;
                chk({tag, "_req_wait"},   dbus_req,  0);
                chk({tag, "_stall_wait"}, lsu_stall, 1);
                chk({tag, "_rdata_wait"}, lsu_rdata, 0);
                next_cycle();
            end
        end

        // Completion cycle: instruction still held and bus ready, yet no reissue.
        dbus_ready = 1'b1; dbus_rvalid = 1'($urandom % 2); dbus_rdata = $urandom;
        #3;
        chk({tag, "_req_done"},   dbus_req,  0);
        chk({tag, "_stall_done"}, lsu_stall, 0);
        if (!wr) chk({tag, "_rdata_done"}, lsu_rdata, exp_load(rdata, off, int'(size), uns));
        next_cycle();
    endtask

    initial begin
        rst = 1'b0;
        ex_rd = 1'b1; ex_wr = 1'b0; ex_addr = 32'h40; ex_wdata = 32'h0;
        ex_size = 2'b10; ex_uns = 1'b0;
        dbus_ready = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;

        // Reset: outputs quiet whatever the inputs (aligned LW, then misaligned SH).
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            ex_wr = (i == 2); ex_size = (i == 2) ? 2'b01 : 2'b10;
            ex_addr = (i == 2) ? 32'h101 : 32'h40;
            #3;
            chk("rst_req",   dbus_req,  0);
            chk("rst_stall", lsu_stall, 0);
            chk("rst_rdata", lsu_rdata, 0);
            chk("rst_flags", {lsu_load_misalign, lsu_store_misalign}, 0);
            next_cycle();
        end
        rst = 1'b1;
        idle("post_rst");

        // Directed loads/stores.
        do_access("lb_103",  1, 0, 32'h103, 32'h0, 2'b00, 0, 0, 0, 32'h80FF_0000);
        do_access("lhu_102", 1, 0, 32'h102, 32'h0, 2'b01, 1, 0, 0, 32'h8001_1234);
        idle("gap1");
        do_access("sb_201",  0, 1, 32'h201, 32'h0000_00AB, 2'b00, 0, 3, 0, 32'h0);
        do_access("lw_102",  1, 0, 32'h102, 32'h0, 2'b10, 0, 0, 0, 32'h0);
        do_access("sh_101",  0, 1, 32'h101, 32'h0, 2'b01, 0, 0, 0, 32'h0);
        do_access("rdwr_mis", 1, 1, 32'h3, 32'h0, 2'b11, 0, 0, 0, 32'h0);
        do_access("rdwr_st", 1, 1, 32'h8, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 32'h0);
        do_access("lh_neg",  1, 0, 32'h2, 32'h0, 2'b01, 0, 1, 2, 32'hF00D_0000);

        // Back-to-back LW then SW with instant handshakes.
        do_access("b2b_lw", 1, 0, 32'h0, 32'h0, 2'b10, 0, 0, 0, 32'h1357_9BDF);
        do_access("b2b_sw", 0, 1, 32'h4, 32'h2468_ACE0, 2'b10, 0, 0, 0, 32'h0);
        idle("gap2");
        chk("hs_count_b2b", n_hs, n_exp_hs);

        // Reset while waiting for read data: access abandoned, late rvalid ignored.
        ex_rd = 1'b1; ex_wr = 1'b0; ex_addr = 32'h40; ex_size = 2'b10; ex_uns = 1'b0;
        dbus_ready = 1'b1; dbus_rvalid = 1'b0;
        #3;
        chk("rstw_req", dbus_req, 1);
        next_cycle();
        n_exp_hs++;
        rst = 1'b0; dbus_ready = 1'b0;
        #3;
        chk("rstw_stall_rst", lsu_stall, 0);
        chk("rstw_req_rst",   dbus_req,  0);
        next_cycle();
        rst = 1'b1; ex_rd = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
        #3;
        chk("rstw_stall_after", lsu_stall, 0);
        chk("rstw_rdata_after", lsu_rdata, 0);
        next_cycle();
        dbus_rvalid = 1'b0;
        #3;
        chk("rstw_no_done", lsu_rdata, 0);
        chk("rstw_stall_idle", lsu_stall, 0);
        next_cycle();

        // Reset while request pending without ready: nothing accepted.
        ex_rd = 1'b1; ex_addr = 32'h80; dbus_ready = 1'b0;
        #3;
        chk("rstr_req", dbus_req, 1);
        next_cycle();
        rst = 1'b0; dbus_ready = 1'b1;
        #3;
        chk("rstr_req_rst", dbus_req, 0);
        next_cycle();
        rst = 1'b1;
        idle("rstr_idle");
        do_access("after_rst", 1, 0, 32'h41, 32'h0, 2'b00, 1, 1, 1, 32'h00C3_0000);

        // Random transactions.
        for (int t = 0; t < 60; t++) begin
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            do_access("rnd", op[0], op[1], $urandom, $urandom, 2'($urandom % 4),
                      1'($urandom % 2), int'($urandom % 4), int'($urandom % 4), $urandom);
            if ($urandom % 4 == 0) idle("rnd_gap");
        end
        idle("final");
        chk("hs_count_final", n_hs, n_exp_hs);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: AW, 32, data-bus address width.
REQ-002 Parameter: DW, 32, data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 ex2mem_mem_rd  input  1  load in EX/MEM register.
REQ-006 ex2mem_mem_wr  input  1  store in EX/MEM register.
REQ-007 ex2mem_alu_out  input  AW  effective address.
REQ-008 ex2mem_mem_wdata  input  DW  store data, LSB-aligned.
REQ-009 ex2mem_mem_size  input  2  access size: 00 byte, 01 half, 10/11 word.
REQ-010 ex2mem_mem_unsigned  input  1  zero-extend loads (LBU/LHU).
REQ-011 dbus_req  output  1  bus request.
REQ-012 dbus_wr  output  1  1 = write.
REQ-013 dbus_addr  output  AW  word-aligned address ({addr[AW-1:2],2'b00}).
REQ-014 dbus_wdata  output  DW  lane-replicated write data.
REQ-015 dbus_byteen  output  4  byte enables.
REQ-016 dbus_ready  input  1  request accepted this cycle.
REQ-017 dbus_rvalid  input  1  read data valid.
REQ-018 dbus_rdata  input  DW  read data.
REQ-019 lsu_rdata  output  DW  formatted load data to MEM stage.
REQ-020 lsu_stall  output  1  hold IF..EX/MEM pipeline registers.
REQ-021 lsu_load_misalign  output  1  misaligned load exception.
REQ-022 lsu_store_misalign  output  1  misaligned store exception.

Function
REQ-023 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-024 access = (mem_rd|mem_wr) & !misalign; misalign = (size==01 & addr[0]) | (size[1] & addr[1:0]!=0).
REQ-025 In IDLE with access, dbus_req SHALL be 1 combinationally and held, with addr/wr/wdata/byteen stable, until dbus_ready.
REQ-026 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-027 dbus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-028 IDLE, access, dbus_ready: store -> DONE; load -> WAIT; addr[1:0], size, unsigned captured. No dbus_ready -> stay IDLE.
REQ-029 WAIT: on dbus_rvalid, capture dbus_rdata, go DONE; otherwise stay. dbus_rvalid is ignored outside WAIT.
REQ-030 DONE SHALL last exactly one cycle, issue no request, then go IDLE (so a held instruction is never reissued).
REQ-031 lsu_stall = (IDLE & access) | WAIT; 0 in DONE.
REQ-032 In DONE, lsu_rdata = captured word >> (8*addr[1:0]), truncated to the captured size, then sign- or zero-extended per captured unsigned. Else lsu_rdata = 0.
REQ-033 Misaligned access: no dbus_req, lsu_stall=0, exception flag=1 combinationally in same cycle, lsu_rdata=0.
REQ-034 mem_rd and mem_wr both 1: treated as store.
REQ-035 Minimum load latency: request accepted cycle N, rvalid earliest N+1, data presented in DONE at N+2.
REQ-036 Minimum store latency: accepted cycle N (stall=1), DONE at N+1 (stall=0).

Reset
REQ-037 rst=0 at clock edge: state=IDLE, captured data/attributes=0.
REQ-038 During reset: dbus_req, lsu_stall, lsu_rdata, and both misalign flags SHALL be 0 regardless of inputs.
REQ-039 Reset mid-transaction (REQ or WAIT) SHALL abandon the access; a later dbus_rvalid in IDLE is ignored.

Verification
REQ-040 LB addr=0x103, rdata=0x80FF_0000, ready same cycle, rvalid next -> byteen=1000, lsu_rdata=0xFFFF_FF80 in DONE, stall 2 cycles.
REQ-041 LHU addr=0x102, rdata=0x8001_1234 -> byteen=1100, lsu_rdata=0x0000_8001.
REQ-042 SB addr=0x201, wdata=0x0000_00AB, dbus_ready delayed 3 cycles -> req held 4 cycles, wdata=0xABAB_ABAB, byteen=0010, stall drops in DONE.
REQ-043 LW addr=0x102 -> load_misalign=1, dbus_req=0, stall=0; SH addr=0x101 -> store_misalign=1.
REQ-044 LW issued, rst=0 while in WAIT, then rvalid -> state IDLE, no DONE, lsu_rdata=0, stall=0.
REQ-045 Back-to-back LW 0x0 then SW 0x4 with instant ready/rvalid -> second request only after DONE, each access issued exactly once.
